// File: rtl/adder_ctrl.sv
// rtl/adder_ctrl.sv - AXI-lite master that writes two operands to an adder slave and reads back the sum
//
// Ports:
//   ACLK, ARESET          clock (rising edge), synchronous active-high reset
//   start, op_a, op_b     request one add transaction; operands latched on acceptance
//   busy, done            busy outside IDLE; done is a one-cycle completion pulse
//   result, error         last read sum; error response seen in last transaction
//   AW*/W*/B*             write address, write data and write response channels
//   AR*/R*                read address and read data channels (RESP bit 1 = error)
//
// Optional feature: define ADDER_CTRL_ERR_CHECK_EN to honour BRESP/RRESP error
// responses (abort to DONE on a write error, flag error on a read error).
// Without it the responses are ignored, error stays 0 and the full sequence always runs.

module adder_ctrl #(
    parameter int                      DATA_WIDTH   = 32,
    parameter int                      ADDRESS_SIZE = 8,
    parameter logic [ADDRESS_SIZE-1:0] ADDR_A       = ADDRESS_SIZE'('h00),
    parameter logic [ADDRESS_SIZE-1:0] ADDR_B       = ADDRESS_SIZE'('h04),
    parameter logic [ADDRESS_SIZE-1:0] ADDR_RES     = ADDRESS_SIZE'('h08)
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   op_a,
    input  logic [DATA_WIDTH-1:0]   op_b,
    output logic                    busy,
    output logic                    done,
    output logic [DATA_WIDTH-1:0]   result,
    output logic                    error,
    output logic [ADDRESS_SIZE-1:0] AWADDR,
    output logic                    AWVALID,
    input  logic                    AWREADY,
    output logic [DATA_WIDTH-1:0]   WDATA,
    output logic                    WSTRB,
    output logic                    WVALID,
    input  logic                    WREADY,
    input  logic                    BRESP,
    input  logic                    BVALID,
    output logic                    BREADY,
    output logic [ADDRESS_SIZE-1:0] ARADDR,
    output logic                    ARVALID,
    input  logic                    ARREADY,
    input  logic [DATA_WIDTH-1:0]   RDATA,
    input  logic                    RRESP,
    input  logic                    RVALID,
    output logic                    RREADY
);

    typedef enum logic [2:0] {
        IDLE,
        WR_A,
        WR_A_RESP,
        WR_B,
        WR_B_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] op_b_q;
    logic                  wr_both_done;
    logic                  b_err;
    logic                  r_err;

`ifdef ADDER_CTRL_ERR_CHECK_EN
    assign b_err = BRESP;
    assign r_err = RRESP;
`else
    logic unused_resp;
    assign b_err       = 1'b0;
    assign r_err       = 1'b0;
    assign unused_resp = BRESP ^ RRESP;
`endif

    // Strobe is meaningful only alongside write data, and the single lane is always written.
    assign WSTRB = WVALID;

    // A channel counts as finished once its VALID has dropped or it handshakes this cycle,
    // so AW and W may complete in the same or in different cycles.
    assign wr_both_done = (!AWVALID || AWREADY) && (!WVALID || WREADY);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            error   <= 1'b0;
            AWADDR  <= '0;
            AWVALID <= 1'b0;
            WDATA   <= '0;
            WVALID  <= 1'b0;
            BREADY  <= 1'b0;
            ARADDR  <= '0;
            ARVALID <= 1'b0;
            RREADY  <= 1'b0;
            op_b_q  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // op_a goes straight into WDATA; op_b is held for the second write.
                        busy    <= 1'b1;
                        error   <= 1'b0;
                        op_b_q  <= op_b;
                        AWADDR  <= ADDR_A;
                        WDATA   <= op_a;
                        AWVALID <= 1'b1;
                        WVALID  <= 1'b1;
                        state   <= WR_A;
                    end
                end

                WR_A, WR_B: begin
                    if (AWVALID && AWREADY) begin
                        AWVALID <= 1'b0;
                    end
                    if (WVALID && WREADY) begin
                        WVALID <= 1'b0;
                    end
                    if (wr_both_done) begin
                        BREADY <= 1'b1;
                        state  <= (state == WR_A) ? WR_A_RESP : WR_B_RESP;
                    end
                end

                WR_A_RESP, WR_B_RESP: begin
                    if (BVALID) begin
                        BREADY <= 1'b0;
                        if (b_err) begin
                            error <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (state == WR_A_RESP) begin
                            AWADDR  <= ADDR_B;
                            WDATA   <= op_b_q;
                            AWVALID <= 1'b1;
                            WVALID  <= 1'b1;
                            state   <= WR_B;
                        end else begin
                            ARADDR  <= ADDR_RES;
                            ARVALID <= 1'b1;
                            state   <= RD_ADDR;
                        end
                    end
                end

                RD_ADDR: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        state   <= RD_DATA;
                    end
                end

                RD_DATA: begin
                    if (RVALID) begin
                        // Data is captured even on an error response.
                        RREADY <= 1'b0;
                        result <= RDATA;
                        if (r_err) begin
                            error <= 1'b1;
                        end
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_ctrl.sv
// tb/tb_adder_ctrl.sv - scoreboard bench for adder_ctrl with a behavioural AXI-lite adder slave

module tb_adder_ctrl;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam logic [AW-1:0] A_ADDR   = 8'h00;
    localparam logic [AW-1:0] B_ADDR   = 8'h04;
    localparam logic [AW-1:0] RES_ADDR = 8'h08;

    logic          ACLK   = 1'b0;
    logic          ARESET = 1'b1;
    logic          start  = 1'b0;
    logic [DW-1:0] op_a   = '0;
    logic [DW-1:0] op_b   = '0;
    logic          busy, done, error;
    logic [DW-1:0] result;
    logic [AW-1:0] AWADDR, ARADDR;
    logic          AWVALID, WVALID, WSTRB, BREADY, ARVALID, RREADY;
    logic [DW-1:0] WDATA;
    logic          AWREADY = 1'b0, WREADY = 1'b0, ARREADY = 1'b0;
    logic          BVALID = 1'b0, BRESP = 1'b0, RVALID = 1'b0, RRESP = 1'b0;
    logic [DW-1:0] RDATA = '0;

    adder_ctrl dut (
        .ACLK(ACLK), .ARESET(ARESET), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .result(result), .error(error),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        checks++;
        $display("FAIL %s: got %0h expected none (cycle %0d)", name, act, cyc);
    endtask

    // Reference model: expected AXI traffic and completions, computed from operands.
    typedef struct packed {logic [AW-1:0] addr; logic [DW-1:0] data;} wr_t;
    typedef struct packed {logic [DW-1:0] res; logic err;} done_t;
    typedef struct packed {logic [DW-1:0] d; logic e;} rd_t;

    wr_t           exp_wr[$];
    int            exp_rd = 0;
    done_t         exp_done[$];
    logic [DW-1:0] model_result = '0;
    logic          model_err = 1'b0;
    int            start_cyc = 0;
    int            last_done_cyc = 0;

    // Slave state and knobs.
    logic [DW-1:0] reg_a = '0, reg_b = '0;
    logic [AW-1:0] aw_q[$];
    logic [DW-1:0] w_q[$];
    logic          b_q[$];
    rd_t           r_q[$];
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
    int aw_lim = 0, w_lim = 0, ar_lim = 0, b_lim = 0, r_lim = 0;
    int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
    bit rnd = 0, inj_b = 0, inj_r = 0, b_fire = 0, r_fire = 0;
    wr_t sw, se;
    rd_t sr;

    function automatic int pick(input int d);
        if (rnd) return int'($urandom_range(3, 0));
        return d;
    endfunction

    task automatic cfg(input bit r, input int awd, input int wd, input int bd, input int ard, input int rdl);
        rnd = r;
        aw_dly = awd; w_dly = wd; b_dly = bd; ar_dly = ard; r_dly = rdl;
        aw_lim = awd; w_lim = wd; b_lim = bd; ar_lim = ard; r_lim = rdl;
    endtask

    // Slave: everything is updated on the falling edge, so a VALID&READY pair seen
    // here is exactly what the DUT samples at the next rising edge.
    always @(negedge ACLK) begin
        if (ARESET) begin
            AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; BRESP = 0; RVALID = 0; RRESP = 0;
            aw_q.delete(); w_q.delete(); b_q.delete(); r_q.delete();
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
            b_fire = 0; r_fire = 0;
        end else begin
            if (b_fire) begin BVALID = 0; BRESP = 0; b_fire = 0; end
            if (r_fire) begin RVALID = 0; RRESP = 0; r_fire = 0; end
            if (aw_q.size() > 0 && w_q.size() > 0) begin
                sw.addr = aw_q.pop_front();
                sw.data = w_q.pop_front();
                if (exp_wr.size() == 0) fail_now("unexpected_write", {sw.addr, sw.data});
                else begin
                    se = exp_wr.pop_front();
                    chk("write_addr_data", {sw.addr, sw.data}, {se.addr, se.data});
                end
                if (sw.addr == A_ADDR) reg_a = sw.data;
                if (sw.addr == B_ADDR) reg_b = sw.data;
                b_q.push_back(inj_b && sw.addr == A_ADDR);
                if (sw.addr == A_ADDR) inj_b = 0;
            end
            if (!BVALID && b_q.size() > 0) begin
                if (b_cnt >= b_lim) begin
                    BVALID = 1; BRESP = b_q.pop_front(); b_cnt = 0; b_lim = pick(b_dly);
                end else b_cnt++;
            end
            if (BVALID && BREADY) b_fire = 1;
            if (!RVALID && r_q.size() > 0) begin
                if (r_cnt >= r_lim) begin
                    sr = r_q.pop_front();
                    RVALID = 1; RDATA = sr.d; RRESP = sr.e; r_cnt = 0; r_lim = pick(r_dly);
                end else r_cnt++;
            end
            if (RVALID && RREADY) r_fire = 1;

            if (AWVALID) begin AWREADY = (aw_cnt >= aw_lim); aw_cnt++; end
            else begin AWREADY = 0; aw_cnt = 0; end
            if (AWVALID && AWREADY) begin aw_q.push_back(AWADDR); aw_cnt = 0; aw_lim = pick(aw_dly); end

            if (WVALID) begin WREADY = (w_cnt >= w_lim); w_cnt++; end
            else begin WREADY = 0; w_cnt = 0; end
            if (WVALID && WREADY) begin w_q.push_back(WDATA); w_cnt = 0; w_lim = pick(w_dly); end

            if (ARVALID) begin ARREADY = (ar_cnt >= ar_lim); ar_cnt++; end
            else begin ARREADY = 0; ar_cnt = 0; end
            if (ARVALID && ARREADY) begin
                if (exp_rd == 0) fail_now("unexpected_read", ARADDR);
                else begin exp_rd--; chk("read_addr", ARADDR, RES_ADDR); end
                sr.d = (ARADDR == RES_ADDR) ? reg_a + reg_b : 32'hBAD0BAD0;
                sr.e = inj_r;
                inj_r = 0;
                r_q.push_back(sr);
                ar_cnt = 0; ar_lim = pick(ar_dly);
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT signals completion.
    logic  prev_done = 1'b0;
    done_t md;
    always @(negedge ACLK) begin
        if (ARESET) prev_done = 1'b0;
        else begin
            if (prev_done) begin
                chk("done_one_cycle", done, 1'b0);
                chk("busy_after_done", busy, 1'b0);
            end
            if (WVALID) chk("wstrb_with_wvalid", WSTRB, 1'b1);
            if (done) begin
                last_done_cyc = cyc;
                chk("busy_during_done", busy, 1'b1);
                if (exp_done.size() == 0) fail_now("unexpected_done", result);
                else begin
                    md = exp_done.pop_front();
                    chk("result", result, md.res);
                    chk("error", error, md.err);
                end
            end
            prev_done = done;
        end
    end

    task automatic chk_reset(input string name);
        chk({name, "_ctrl"}, {AWVALID, WVALID, WSTRB, BREADY, ARVALID, RREADY, busy, done, error}, '0);
        chk({name, "_result"}, result, '0);
        chk({name, "_addr"}, {AWADDR, ARADDR}, '0);
        chk({name, "_wdata"}, WDATA, '0);
    endtask

    task automatic run_txn(input logic [DW-1:0] a, input logic [DW-1:0] b, input int kind);
        done_t d;
        wr_t   w;
        logic [DW-1:0] sum;
        sum = a + b;
        w.addr = A_ADDR; w.data = a; exp_wr.push_back(w);
`ifdef ADDER_CTRL_ERR_CHECK_EN
        if (kind == 1) begin
            d.res = model_result; d.err = 1'b1;
        end else begin
            w.addr = B_ADDR; w.data = b; exp_wr.push_back(w);
            exp_rd++;
            model_result = sum;
            d.res = sum; d.err = (kind == 2);
        end
`else
        w.addr = B_ADDR; w.data = b; exp_wr.push_back(w);
        exp_rd++;
        model_result = sum;
        d.res = sum; d.err = 1'b0;
`endif
        model_err = d.err;
        exp_done.push_back(d);
        inj_b = (kind == 1);
        inj_r = (kind == 2);
        op_a = a; op_b = b; start = 1'b1; start_cyc = cyc;
        @(negedge ACLK);
        start = 1'b0;
        op_a = $urandom; op_b = $urandom;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_done.size() != 0 || busy) && n < 300) begin
            @(negedge ACLK);
            n++;
        end
        chk({name, "_completes"}, n < 300, 1'b1);
        chk({name, "_result_hold"}, result, model_result);
        chk({name, "_error_hold"}, error, model_err);
    endtask

    function automatic logic [DW-1:0] rnd_op();
        case ($urandom_range(3, 0))
            0: return '0;
            1: return '1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int n;
        cfg(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge ACLK);
        chk_reset("reset");
        ARESET = 1'b0;
        @(negedge ACLK);

        // Basic 5 + 7 with an always-ready slave, including latency.
        run_txn(5, 7, 0);
        wait_idle("basic");
        chk("latency", last_done_cyc - start_cyc + 1, 8);
        chk("basic_sum", result, 12);

        // AWREADY three cycles ahead of WREADY.
        cfg(0, 0, 3, 0, 0, 0);
        run_txn(rnd_op(), rnd_op(), 0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (!AWVALID && WVALID && AWADDR == A_ADDR && !BREADY) seen = 1;
            @(negedge ACLK);
        end
        chk("aw_drops_w_held", seen, 1'b1);
        wait_idle("split");

        // start while busy is ignored.
        cfg(0, 0, 0, 0, 0, 0);
        run_txn(32'd100, 32'd23, 0);
        for (int i = 0; i < 3; i++) begin
            start = 1'b1; op_a = 1;
            @(negedge ACLK);
            start = 1'b0;
            @(negedge ACLK);
        end
        wait_idle("busy_start");
        chk("busy_start_sum", result, 123);

        // Reset while waiting on the second write response.
        cfg(0, 0, 0, 6, 0, 0);
        run_txn(rnd_op(), rnd_op(), 0);
        n = 0;
        while (!(BREADY && AWADDR == B_ADDR) && n < 50) begin @(negedge ACLK); n++; end
        chk("reached_wr_b_resp", n < 50, 1'b1);
        ARESET = 1'b1;
        @(negedge ACLK);
        chk_reset("mid_reset");
        exp_wr.delete(); exp_done.delete(); exp_rd = 0;
        model_result = '0; model_err = 1'b0;
        @(negedge ACLK);
        ARESET = 1'b0;
        cfg(0, 0, 0, 0, 0, 0);
        @(negedge ACLK);
        run_txn(rnd_op(), rnd_op(), 0);
        wait_idle("after_reset");

        // Error responses on the first write and on the read.
        run_txn(32'd9, 32'd4, 1);
        wait_idle("bresp_err");
        run_txn(rnd_op(), rnd_op(), 2);
        wait_idle("rresp_err");
        run_txn(rnd_op(), rnd_op(), 0);
        wait_idle("err_cleared");

        // Randomized traffic with random handshake delays.
        cfg(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            n = int'($urandom_range(5, 0));
            run_txn(rnd_op(), rnd_op(), (n <= 2) ? n : 0);
            wait_idle("random");
        end

        chk("leftover_writes", exp_wr.size(), 0);
        chk("leftover_reads", exp_rd, 0);
        chk("leftover_done", exp_done.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
